// File: rtl/seq_stage_ctrl.sv
// Y86 SEQ multi-cycle sequencer: one-hot registered stage enables, CC gating, MEMORY ack/timeout, status word, perf counters.
// 4 cycles per non-memory instr, +N for MEMORY (held until mem_ack); SEQ_SINGLE_STEP_EN adds i_step and a PAUSE state after PCUPD.
module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_icode,
  input  logic             i_instr_valid,
  input  logic             i_imem_error,
  input  logic             i_mem_error,
  input  logic             i_mem_ack,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             i_step,
`endif
  output logic             o_fetch_en,
  output logic             o_decode_en,
  output logic             o_exec_en,
  output logic             o_mem_en,
  output logic             o_pc_en,
  output logic             o_cc_en,
  output logic [3:0]       o_stat,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_PCUPD   = 3'd5,
`ifdef SEQ_SINGLE_STEP_EN
    S_PAUSE   = 3'd7,
`endif
    S_HALT    = 3'd6
  } state_t;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [3:0]       w_stat;
  logic [3:0]       r_stat;
  logic [3:0]       r_icode;
  logic [7:0]       r_timer;
  logic             r_fetch_en, r_decode_en, r_exec_en, r_mem_en, r_pc_en, r_cc_en, r_busy;
  logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;
  logic             w_is_mem;
  logic             w_active;

  assign w_is_mem = (r_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
  assign w_active = (r_state inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_PCUPD});

  always_comb begin
    w_nxt  = r_state;
    w_stat = r_stat;
    case (r_state)
      S_IDLE:    if (i_start) w_nxt = S_FETCH;
      S_FETCH: begin
        if (!i_instr_valid) begin
          w_nxt  = S_HALT;
          w_stat = STAT_INS;
        end else if (i_imem_error) begin
          w_nxt  = S_HALT;
          w_stat = STAT_ADR;
        end else if (i_icode == 4'h0) begin
          w_nxt  = S_HALT;
          w_stat = STAT_HLT;
        end else begin
          w_nxt  = S_DECODE;
        end
      end
      S_DECODE:  w_nxt = S_EXECUTE;
      S_EXECUTE: w_nxt = w_is_mem ? S_MEMORY : S_PCUPD;
      // An ack arriving on the last allowed cycle still beats the timeout.
      S_MEMORY: begin
        if (i_mem_ack) begin
          if (i_mem_error) begin
            w_nxt  = S_HALT;
            w_stat = STAT_ADR;
          end else begin
            w_nxt  = S_PCUPD;
          end
        end else if (r_timer >= TMO_LAST) begin
          w_nxt  = S_HALT;
          w_stat = STAT_ADR;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PCUPD:   w_nxt = S_PAUSE;
      S_PAUSE:   if (i_step) w_nxt = S_FETCH;
`else
      S_PCUPD:   w_nxt = S_FETCH;
`endif
      S_HALT:    w_nxt = S_HALT;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_stat      <= STAT_AOK;
      r_icode     <= 4'h0;
      r_timer     <= 8'd0;
      r_fetch_en  <= 1'b0;
      r_decode_en <= 1'b0;
      r_exec_en   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_pc_en     <= 1'b0;
      r_cc_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state     <= w_nxt;
      r_stat      <= w_stat;
      if (r_state == S_FETCH) r_icode <= i_icode;
      // Timer is zero in every other state, so each MEMORY visit starts fresh.
      r_timer     <= (r_state == S_MEMORY) ? r_timer + 8'd1 : 8'd0;
      r_fetch_en  <= (w_nxt == S_FETCH);
      r_decode_en <= (w_nxt == S_DECODE);
      r_exec_en   <= (w_nxt == S_EXECUTE);
      r_mem_en    <= (w_nxt == S_MEMORY);
      r_pc_en     <= (w_nxt == S_PCUPD);
      r_cc_en     <= (w_nxt == S_EXECUTE) && (r_icode == 4'h6);
      r_busy      <= (w_nxt inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_PCUPD});
      if (w_active)            r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (r_state == S_PCUPD)  r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign o_fetch_en  = r_fetch_en;
  assign o_decode_en = r_decode_en;
  assign o_exec_en   = r_exec_en;
  assign o_mem_en    = r_mem_en;
  assign o_pc_en     = r_pc_en;
  assign o_cc_en     = r_cc_en;
  assign o_stat      = r_stat;
  assign o_busy      = r_busy;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl; enables checked as {fetch,decode,exec,mem,pc,cc}.
module tb_seq_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, instr_valid, imem_error, mem_error, mem_ack;
  logic [3:0]  icode;
  logic        fetch_en, decode_en, exec_en, mem_en, pc_en, cc_en, busy;
  logic [3:0]  stat;
  logic [31:0] cycle_cnt, instr_cnt;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_stage_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_icode(icode),
    .i_instr_valid(instr_valid), .i_imem_error(imem_error),
    .i_mem_error(mem_error), .i_mem_ack(mem_ack),
`ifdef SEQ_SINGLE_STEP_EN
    .i_step(step),
`endif
    .o_fetch_en(fetch_en), .o_decode_en(decode_en), .o_exec_en(exec_en),
    .o_mem_en(mem_en), .o_pc_en(pc_en), .o_cc_en(cc_en), .o_stat(stat),
    .o_busy(busy), .o_cycle_cnt(cycle_cnt), .o_instr_cnt(instr_cnt)
  );

  function automatic logic [5:0] ens();
    return {fetch_en, decode_en, exec_en, mem_en, pc_en, cc_en};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs changed afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; icode = 4'h0; instr_valid = 1'b1;
    imem_error = 1'b0; mem_error = 1'b0; mem_ack = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic kick(input logic [3:0] ic);
    icode = ic; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int n;

  initial begin
    do_reset();
    chk("rst_en", ens(), 6'b000000);
    chk("rst_stat", stat, 4'b1000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cyc", cycle_cnt, 0);
    chk("rst_ins", instr_cnt, 0);

    // OPq: four stages, CC written in EXECUTE
    kick(4'h6);
    chk("op_fetch", ens(), 6'b100000);
    chk("op_busy", busy, 1'b1);
    tick(); chk("op_decode", ens(), 6'b010000);
    tick(); chk("op_exec", ens(), 6'b001001);
    tick(); chk("op_pc", ens(), 6'b000010);
    tick(); chk("op_refetch", ens(), 6'b100000);
    chk("op_ins", instr_cnt, 1);
    chk("op_cyc", cycle_cnt, 4);

    // mrmovq, ack on 3rd MEMORY cycle; stray ack/err in DECODE ignored
    do_reset();
    kick(4'h5);
    mem_ack = 1'b1; mem_error = 1'b1;
    tick(); chk("mr_decode", ens(), 6'b010000);
    mem_ack = 1'b0; mem_error = 1'b0;
    tick(); chk("mr_exec", ens(), 6'b001000);
    tick(); chk("mr_mem1", ens(), 6'b000100);
    tick(); chk("mr_mem2", ens(), 6'b000100);
    tick(); chk("mr_mem3", ens(), 6'b000100);
    mem_ack = 1'b1;
    tick(); chk("mr_pc", ens(), 6'b000010);
    chk("mr_cyc_pc", cycle_cnt, 6);
    mem_ack = 1'b0;
    tick(); chk("mr_cyc_exit", cycle_cnt, 7);
    chk("mr_ins", instr_cnt, 1);
    chk("mr_stat", stat, 4'b1000);

    // halt instruction, start afterwards ignored
    do_reset();
    kick(4'h0);
    tick();
    chk("hlt_stat", stat, 4'b0100);
    chk("hlt_busy", busy, 1'b0);
    chk("hlt_en", ens(), 6'b000000);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("hlt_sticky_en", ens(), 6'b000000);
    chk("hlt_sticky_stat", stat, 4'b0100);
    chk("hlt_cyc", cycle_cnt, 1);

    // fault priority
    do_reset();
    instr_valid = 1'b0; imem_error = 1'b1;
    kick(4'h6); tick();
    chk("ins_wins", stat, 4'b0001);
    do_reset();
    imem_error = 1'b1;
    kick(4'h6); tick();
    chk("imem_adr", stat, 4'b0010);

    // timeout: no ack ever
    do_reset();
    kick(4'hA); tick(); tick(); tick();
    n = 0;
    while (mem_en && n < 40) begin
      n++;
      tick();
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_stat", stat, 4'b0010);
    chk("tmo_en", ens(), 6'b000000);

    // ack on exactly the last allowed MEMORY cycle is accepted
    do_reset();
    kick(4'h9); tick(); tick(); tick();
    for (int i = 0; i < 15; i++) tick();
    chk("edge_mem16", ens(), 6'b000100);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("edge_pc", ens(), 6'b000010);
    chk("edge_stat", stat, 4'b1000);

    // memory error with ack
    do_reset();
    kick(4'h4); tick(); tick(); tick();
    mem_ack = 1'b1; mem_error = 1'b1;
    tick(); mem_ack = 1'b0; mem_error = 1'b0;
    chk("merr_stat", stat, 4'b0010);
    chk("merr_en", ens(), 6'b000000);
    chk("merr_ins", instr_cnt, 0);

    // reset in the middle of MEMORY
    do_reset();
    kick(4'hB); tick(); tick(); tick(); tick();
    chk("mrst_pre", ens(), 6'b000100);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    chk("mrst_en", ens(), 6'b000000);
    chk("mrst_stat", stat, 4'b1000);
    chk("mrst_cyc", cycle_cnt, 0);
    chk("mrst_busy", busy, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
    do_reset();
    kick(4'h6); tick(); tick(); tick(); tick();
    chk("ss_pause_en", ens(), 6'b000000);
    chk("ss_pause_busy", busy, 1'b0);
    tick(); tick();
    chk("ss_cyc_frozen", cycle_cnt, 4);
    step = 1'b1; tick(); step = 1'b0;
    chk("ss_refetch", ens(), 6'b100000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
